md_sched: RTL and testbench

- Sequencer and owner of the HI/LO multiply/divide resource in the 5-stage pipeline.
- Accepts a multi-cycle mult/div or a single-cycle mthi/mtlo issued from EX.
- Models the iterative unit's latency with a busy counter and commits results to HI/LO.
- Drives the ID-stage stall so no md-class instruction leaves ID while the unit is started or busy.

---
 rtl/md_sched.sv | 160 ++++++++++++++++
 tb/tb_md_sched.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
`default_nettype none
// ============================================================================
// Module      : md_sched
// Description : HI/LO multiply/divide sequencer with busy counter, shadow
//               result registers and ID-stage stall generation.
//               Optional madd/maddu accumulate support under MD_MADD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module md_sched #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_start,
  input  logic [2:0]  ex_mdop,
  input  logic [31:0] ex_rs,
  input  logic [31:0] ex_rt,
  input  logic        id_md_use,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] C_MULT_CYC = 4'(MULT_CYC);
  localparam logic [3:0] C_DIV_CYC  = 4'(DIV_CYC);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_shadow_hi;
  logic [31:0] r_shadow_lo;
  logic        r_wr;
  logic        r_acc;

  logic        w_is_madd;
  logic        w_is_mul;
  logic        w_is_div;
  logic        w_signed;
  logic [63:0] w_a64;
  logic [63:0] w_b64;
  logic [63:0] w_prod;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_den;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic        w_div0;

`ifdef MD_MADD_EN
  assign w_is_madd = (ex_mdop == 3'd6) || (ex_mdop == 3'd7);
`else
  assign w_is_madd = 1'b0;
`endif

  assign w_is_mul = (ex_mdop == 3'd0) || (ex_mdop == 3'd1) || w_is_madd;
  assign w_is_div = (ex_mdop == 3'd2) || (ex_mdop == 3'd3);
  assign w_signed = ~ex_mdop[0];

  // Sign/zero extension to 64 bits lets one multiplier serve both flavours.
  assign w_a64  = w_signed ? {{32{ex_rs[31]}}, ex_rs} : {32'd0, ex_rs};
  assign w_b64  = w_signed ? {{32{ex_rt[31]}}, ex_rt} : {32'd0, ex_rt};
  assign w_prod = w_a64 * w_b64;

  // Sign-magnitude division; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign w_neg_a = w_signed & ex_rs[31];
  assign w_neg_b = w_signed & ex_rt[31];
  assign w_mag_a = w_neg_a ? (~ex_rs + 32'd1) : ex_rs;
  assign w_mag_b = w_neg_b ? (~ex_rt + 32'd1) : ex_rt;
  assign w_div0  = (ex_rt == 32'd0);
  assign w_den   = w_div0 ? 32'd1 : w_mag_b;
  assign w_q     = w_mag_a / w_den;
  assign w_r     = w_mag_a % w_den;
  assign w_quot  = (w_neg_a ^ w_neg_b) ? (~w_q + 32'd1) : w_q;
  assign w_rem   = w_neg_a ? (~w_r + 32'd1) : w_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_busy      <= 1'b0;
      r_hi        <= 32'd0;
      r_lo        <= 32'd0;
      r_shadow_hi <= 32'd0;
      r_shadow_lo <= 32'd0;
      r_wr        <= 1'b0;
      r_acc       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ex_start) begin
            if (w_is_mul || w_is_div) begin
              if (w_is_div) begin
                r_shadow_hi <= w_rem;
                r_shadow_lo <= w_quot;
                r_cnt       <= C_DIV_CYC;
                r_wr        <= ~w_div0;
              end else begin
                r_shadow_hi <= w_prod[63:32];
                r_shadow_lo <= w_prod[31:0];
                r_cnt       <= C_MULT_CYC;
                r_wr        <= 1'b1;
              end
              r_acc   <= w_is_madd;
              r_busy  <= 1'b1;
              r_state <= S_RUN;
            end else if (ex_mdop == 3'd4) begin
              r_hi <= ex_rs;
            end else if (ex_mdop == 3'd5) begin
              r_lo <= ex_rs;
            end
          end
        end
        S_RUN: begin
          // Starts arriving here are ignored; the stall keeps them from issuing.
          if (r_cnt == 4'd1) begin
            if (r_wr) begin
              if (r_acc) begin
                {r_hi, r_lo} <= {r_hi, r_lo} + {r_shadow_hi, r_shadow_lo};
              end else begin
                r_hi <= r_shadow_hi;
                r_lo <= r_shadow_lo;
              end
            end
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign hi       = r_hi;
  assign lo       = r_lo;
  // Gated by reset so a start presented during reset cannot raise the stall.
  assign stall_md = id_md_use & reset & (r_busy | ex_start);

endmodule
`default_nettype wire

// File: tb/tb_md_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_sched
// Description : Directed self-checking bench for md_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_sched;

  logic        clk;
  logic        reset;
  logic        ex_start;
  logic [2:0]  ex_mdop;
  logic [31:0] ex_rs;
  logic [31:0] ex_rt;
  logic        id_md_use;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec;
  int n_err;

  md_sched #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .ex_start (ex_start),
    .ex_mdop  (ex_mdop),
    .ex_rs    (ex_rs),
    .ex_rt    (ex_rt),
    .id_md_use(id_md_use),
    .busy     (busy),
    .stall_md (stall_md),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present an op for one cycle; returns #1 after the issuing edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    ex_start = 1'b1;
    ex_mdop  = op;
    ex_rs    = a;
    ex_rt    = b;
    @(posedge clk);
    #1;
    ex_start = 1'b0;
  endtask

  // Counts busy cycles sampled at negedges; stops at the first idle sample.
  task automatic count_busy(output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset     = 1'b0;
    ex_start  = 1'b1;
    ex_mdop   = 3'd0;
    ex_rs     = 32'h5;
    ex_rt     = 32'h7;
    id_md_use = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_err++;
      $display("FAIL reset_state: busy=%b hi=%h lo=%h, want 0/0/0", busy, hi, lo);
    end
    n_vec++;
    if (stall_md !== 1'b0) begin
      n_err++;
      $display("FAIL reset_stall: stall_md=%b, want 0", stall_md);
    end
    ex_start  = 1'b0;
    id_md_use = 1'b0;
    reset     = 1'b1;
  endtask

  task automatic test_mult;
    int n;
    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    count_busy(n);
    n_vec++;
    if (n !== 5) begin
      n_err++;
      $display("FAIL mult_busy: got %0d cycles, want 5", n);
    end
    n_vec++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      n_err++;
      $display("FAIL mult_result: hi=%h lo=%h, want ffffffff fffffffa", hi, lo);
    end
  endtask

  task automatic test_multu;
    int n;
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    count_busy(n);
    n_vec++;
    if (n !== 5 || hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      n_err++;
      $display("FAIL multu: n=%0d hi=%h lo=%h, want 5 fffffffe 00000001", n, hi, lo);
    end
  endtask

  task automatic test_div;
    int n;
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    count_busy(n);
    n_vec++;
    if (n !== 10) begin
      n_err++;
      $display("FAIL div_busy: got %0d cycles, want 10", n);
    end
    n_vec++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      n_err++;
      $display("FAIL div_result: hi=%h lo=%h, want ffffffff fffffffd", hi, lo);
    end
    issue(3'd3, 32'd7, 32'd0);
    count_busy(n);
    n_vec++;
    if (n !== 10 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      n_err++;
      $display("FAIL divu_zero: n=%0d hi=%h lo=%h, want 10 ffffffff fffffffd", n, hi, lo);
    end
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(n);
    n_vec++;
    if (hi !== 32'h0 || lo !== 32'h8000_0000) begin
      n_err++;
      $display("FAIL div_ovf: hi=%h lo=%h, want 00000000 80000000", hi, lo);
    end
    issue(3'd3, 32'd100, 32'd7);
    count_busy(n);
    n_vec++;
    if (hi !== 32'd2 || lo !== 32'd14) begin
      n_err++;
      $display("FAIL divu: hi=%h lo=%h, want 00000002 0000000e", hi, lo);
    end
  endtask

  task automatic test_stall;
    int n;
    int bad;
    @(negedge clk);
    id_md_use = 1'b1;
    ex_start  = 1'b1;
    ex_mdop   = 3'd2;
    ex_rs     = 32'd9;
    ex_rt     = 32'd4;
    #1;
    n_vec++;
    if (stall_md !== 1'b1) begin
      n_err++;
      $display("FAIL stall_issue: stall_md=%b, want 1", stall_md);
    end
    @(posedge clk);
    #1;
    ex_start = 1'b0;
    n   = 0;
    bad = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      n++;
      if (stall_md !== 1'b1) bad++;
      @(negedge clk);
    end
    n_vec++;
    if (n !== 10 || bad !== 0) begin
      n_err++;
      $display("FAIL stall_busy: n=%0d low_samples=%0d, want 10 0", n, bad);
    end
    n_vec++;
    if (stall_md !== 1'b0) begin
      n_err++;
      $display("FAIL stall_after: stall_md=%b, want 0", stall_md);
    end
    id_md_use = 1'b0;
    issue(3'd2, 32'd9, 32'd4);
    n   = 0;
    bad = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      n++;
      if (stall_md !== 1'b0) bad++;
      @(negedge clk);
    end
    n_vec++;
    if (n !== 10 || bad !== 0) begin
      n_err++;
      $display("FAIL stall_nouse: n=%0d high_samples=%0d, want 10 0", n, bad);
    end
  endtask

  task automatic test_mthi_mtlo;
    issue(3'd4, 32'h1234_5678, 32'd0);
    n_vec++;
    if (hi !== 32'h1234_5678 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL mthi: hi=%h busy=%b, want 12345678 0", hi, busy);
    end
    issue(3'd5, 32'hCAFE_F00D, 32'd0);
    n_vec++;
    if (lo !== 32'hCAFE_F00D || hi !== 32'h1234_5678 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL mtlo: hi=%h lo=%h busy=%b, want 12345678 cafef00d 0", hi, lo, busy);
    end
  endtask

  task automatic test_ignore_in_run;
    int n;
    issue(3'd0, 32'd2, 32'd3);
    issue(3'd0, 32'd7, 32'd7);
    count_busy(n);
    n_vec++;
    if (n !== 4 || hi !== 32'd0 || lo !== 32'd6) begin
      n_err++;
      $display("FAIL run_ignore: n=%0d hi=%h lo=%h, want 4 00000000 00000006", n, hi, lo);
    end
    issue(3'd4, 32'h5555_0000, 32'd0);
    n_vec++;
    if (hi !== 32'h5555_0000 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_ignore: hi=%h busy=%b, want 55550000 0", hi, busy);
    end
  endtask

  task automatic test_reset_mid_run;
    issue(3'd2, 32'd100, 32'd7);
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_err++;
      $display("FAIL reset_mid_run: busy=%b hi=%h lo=%h, want 0 0 0", busy, hi, lo);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_err++;
      $display("FAIL reset_lost_result: busy=%b hi=%h lo=%h, want 0 0 0", busy, hi, lo);
    end
  endtask

  task automatic test_madd;
    int n;
`ifdef MD_MADD_EN
    issue(3'd4, 32'd0, 32'd0);
    issue(3'd5, 32'hFFFF_FFFF, 32'd0);
    issue(3'd7, 32'd1, 32'd1);
    count_busy(n);
    n_vec++;
    if (n !== 5 || hi !== 32'd1 || lo !== 32'd0) begin
      n_err++;
      $display("FAIL maddu: n=%0d hi=%h lo=%h, want 5 00000001 00000000", n, hi, lo);
    end
    issue(3'd6, 32'hFFFF_FFFF, 32'd3);
    count_busy(n);
    n_vec++;
    if (hi !== 32'd0 || lo !== 32'hFFFF_FFFD) begin
      n_err++;
      $display("FAIL madd: hi=%h lo=%h, want 00000000 fffffffd", hi, lo);
    end
`else
    issue(3'd4, 32'hAAAA_0001, 32'd0);
    issue(3'd7, 32'd1, 32'd1);
    count_busy(n);
    n_vec++;
    if (n !== 0 || hi !== 32'hAAAA_0001 || lo !== 32'd0) begin
      n_err++;
      $display("FAIL maddu_noop: n=%0d hi=%h lo=%h, want 0 aaaa0001 00000000", n, hi, lo);
    end
    @(negedge clk);
    id_md_use = 1'b1;
    ex_start  = 1'b1;
    ex_mdop   = 3'd6;
    #1;
    n_vec++;
    if (stall_md !== 1'b1) begin
      n_err++;
      $display("FAIL madd_noop_stall: stall_md=%b, want 1", stall_md);
    end
    @(posedge clk);
    #1;
    ex_start = 1'b0;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || stall_md !== 1'b0 || hi !== 32'hAAAA_0001) begin
      n_err++;
      $display("FAIL madd_noop_after: busy=%b stall=%b hi=%h, want 0 0 aaaa0001", busy, stall_md, hi);
    end
    id_md_use = 1'b0;
`endif
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_stall();
    test_mthi_mtlo();
    test_ignore_in_run();
    test_reset_mid_run();
    test_madd();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
